// File: rtl/traffic_light_monitor_if.sv
// rtl/traffic_light_monitor_if.sv - lamp drives, supervisor clear and monitor status bundle
interface traffic_light_monitor_if #(
   parameter int CNT_W = 7
);
   logic             r1;
   logic             y1;
   logic             g1;
   logic             r2;
   logic             y2;
   logic             g2;
   logic             fault_clr;
   logic [2:0]       phase;
   logic             phase_valid;
   logic [CNT_W-1:0] dwell;
   logic             fault;
   logic [2:0]       fault_code;
   logic             fault_evt;

   // Controller/supervisor side: drives lamps and the clear, reads status
   modport master (
      output r1, y1, g1, r2, y2, g2, fault_clr,
      input  phase, phase_valid, dwell, fault, fault_code, fault_evt
   );

   // Monitor side: observes lamps and the clear, reports status
   modport slave (
      input  r1, y1, g1, r2, y2, g2, fault_clr,
      output phase, phase_valid, dwell, fault, fault_code, fault_evt
   );
endinterface

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - lamp-side phase decoder with transition, dwell and stuck checking
module traffic_light_monitor #(
   parameter int MIN_GREEN  = 4,
   parameter int MIN_YELLOW = 2,
   parameter int MAX_DWELL  = 64,
   parameter int CNT_W      = 7
) (
   input  logic                    clk,
   input  logic                    rst_n,
   traffic_light_monitor_if.slave  bus
);
   localparam logic [2:0] PH_G1R2 = 3'd0;
   localparam logic [2:0] PH_Y1R2 = 3'd1;
   localparam logic [2:0] PH_R1R2 = 3'd2;
   localparam logic [2:0] PH_R1G2 = 3'd3;
   localparam logic [2:0] PH_R1Y2 = 3'd4;
   localparam logic [2:0] PH_UNK  = 3'd7;

   localparam logic [2:0] FC_NONE    = 3'd0;
   localparam logic [2:0] FC_PATTERN = 3'd1;
   localparam logic [2:0] FC_EDGE    = 3'd2;
   localparam logic [2:0] FC_YELLOW  = 3'd3;
   localparam logic [2:0] FC_GREEN   = 3'd4;
   localparam logic [2:0] FC_STUCK   = 3'd5;

   localparam logic [CNT_W-1:0] DW_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] DW_MAX   = CNT_W'(MAX_DWELL);
   localparam logic [CNT_W-1:0] DW_MIN_G = CNT_W'(MIN_GREEN);
   localparam logic [CNT_W-1:0] DW_MIN_Y = CNT_W'(MIN_YELLOW);

   logic [2:0]       phase_q, phase_d;
   logic [CNT_W-1:0] dwell_q, dwell_d;
   logic             fault_q, fault_d;
   logic [2:0]       code_q, code_d;
   logic             evt_q, evt_d;
   logic [2:0]       sample_ph;
   logic             edge_ok;
   logic [2:0]       det;

   // Decode the sampled lamp pattern; anything not one of the five legal pairs is UNKNOWN
   always_comb begin
      sample_ph = PH_UNK;
      case ({bus.r1, bus.y1, bus.g1, bus.r2, bus.y2, bus.g2})
         6'b001_100: sample_ph = PH_G1R2;
         6'b010_100: sample_ph = PH_Y1R2;
         6'b100_100: sample_ph = PH_R1R2;
         6'b100_001: sample_ph = PH_R1G2;
         6'b100_010: sample_ph = PH_R1Y2;
         default:    sample_ph = PH_UNK;
      endcase
   end

   // Table of permitted phase changes between two legal phases
   always_comb begin
      edge_ok = 1'b0;
      case ({phase_q, sample_ph})
         {PH_G1R2, PH_Y1R2},
         {PH_Y1R2, PH_R1R2},
         {PH_Y1R2, PH_R1G2},
         {PH_R1R2, PH_R1G2},
         {PH_R1R2, PH_G1R2},
         {PH_R1G2, PH_R1Y2},
         {PH_R1Y2, PH_R1R2},
         {PH_R1Y2, PH_G1R2}: edge_ok = 1'b1;
         default:            edge_ok = 1'b0;
      endcase
   end

   // State register: phase/dwell tracker plus first-fault latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= PH_UNK;
         dwell_q <= '0;
         fault_q <= 1'b0;
         code_q  <= FC_NONE;
         evt_q   <= 1'b0;
      end else begin
         phase_q <= phase_d;
         dwell_q <= dwell_d;
         fault_q <= fault_d;
         code_q  <= code_d;
         evt_q   <= evt_d;
      end
   end

   // Next state: advance phase/dwell, pick the lowest detected code, update the latch
   always_comb begin
      phase_d = phase_q;
      dwell_d = dwell_q;
      det     = FC_NONE;
      if (sample_ph == PH_UNK) begin
         phase_d = PH_UNK;
         dwell_d = '0;
         det     = FC_PATTERN;
      end else if (sample_ph == phase_q) begin
         if (dwell_q >= DW_MAX) begin
            det = FC_STUCK;
         end else begin
            dwell_d = dwell_q + DW_ONE;
         end
      end else begin
         phase_d = sample_ph;
         dwell_d = DW_ONE;
         // Entry from UNKNOWN carries no history, so nothing is checked
         if (phase_q != PH_UNK) begin
            if (!edge_ok) begin
               det = FC_EDGE;
            end else if ((phase_q == PH_Y1R2 || phase_q == PH_R1Y2) && dwell_q < DW_MIN_Y) begin
               det = FC_YELLOW;
            end else if ((phase_q == PH_G1R2 || phase_q == PH_R1G2) && dwell_q < DW_MIN_G) begin
               det = FC_GREEN;
            end
         end
      end

      evt_d   = (det != FC_NONE);
      fault_d = fault_q;
      code_d  = code_q;
      if (bus.fault_clr) begin
         fault_d = 1'b0;
         code_d  = FC_NONE;
      end
      // A detection in the clear cycle re-latches with the fresh code
      if (evt_d && (!fault_q || bus.fault_clr)) begin
         fault_d = 1'b1;
         code_d  = det;
      end
   end

   // Outputs come straight from registers
   always_comb begin
      bus.phase       = phase_q;
      bus.phase_valid = (phase_q != PH_UNK);
      bus.dwell       = dwell_q;
      bus.fault       = fault_q;
      bus.fault_code  = code_q;
      bus.fault_evt   = evt_q;
   end
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - randomized self-checking bench for traffic_light_monitor
module tb_traffic_light_monitor;
   localparam int MIN_GREEN  = 4;
   localparam int MIN_YELLOW = 2;
   localparam int MAX_DWELL  = 64;
   localparam int CNT_W      = 7;

   // Lamp vectors ordered {r1,y1,g1,r2,y2,g2}
   localparam logic [5:0] L_G1R2 = 6'b001_100;
   localparam logic [5:0] L_Y1R2 = 6'b010_100;
   localparam logic [5:0] L_R1R2 = 6'b100_100;
   localparam logic [5:0] L_R1G2 = 6'b100_001;
   localparam logic [5:0] L_R1Y2 = 6'b100_010;
   localparam logic [5:0] L_G1G2 = 6'b001_001;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   traffic_light_monitor_if #(.CNT_W(CNT_W)) tl_if ();

   traffic_light_monitor #(
      .MIN_GREEN(MIN_GREEN), .MIN_YELLOW(MIN_YELLOW), .MAX_DWELL(MAX_DWELL), .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(tl_if)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   int m_phase;
   int m_dwell;
   bit m_fault;
   int m_code;
   bit m_evt;

   int         edges [8][2] = '{'{0,1}, '{1,2}, '{1,3}, '{2,3}, '{2,0}, '{3,4}, '{4,2}, '{4,0}};
   logic [5:0] lamp_of [5];

   function automatic int decode(logic [5:0] l);
      case (l)
         L_G1R2:  return 0;
         L_Y1R2:  return 1;
         L_R1R2:  return 2;
         L_R1G2:  return 3;
         L_R1Y2:  return 4;
         default: return 7;
      endcase
   endfunction

   function automatic bit edge_legal(int a, int b);
      foreach (edges[i]) if (edges[i][0] == a && edges[i][1] == b) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [15:0] exp_vec();
      return {3'(m_phase), (m_phase != 7), 7'(m_dwell), m_fault, 3'(m_code), m_evt};
   endfunction

   function automatic logic [15:0] obs_vec();
      return {tl_if.phase, tl_if.phase_valid, tl_if.dwell, tl_if.fault, tl_if.fault_code, tl_if.fault_evt};
   endfunction

   task automatic model_reset();
      m_phase = 7; m_dwell = 0; m_fault = 0; m_code = 0; m_evt = 0;
   endtask

   task automatic model_sample(logic [5:0] l, bit clr);
      int p;
      int lo;
      p  = decode(l);
      lo = 0;
      if (p == 7) begin
         m_phase = 7; m_dwell = 0; lo = 1;
      end else if (p == m_phase) begin
         if (m_dwell == MAX_DWELL) lo = 5;
         else m_dwell++;
      end else begin
         if (m_phase != 7) begin
            if (!edge_legal(m_phase, p)) lo = 2;
            if (lo == 0 && (m_phase == 1 || m_phase == 4) && m_dwell < MIN_YELLOW) lo = 3;
            if (lo == 0 && (m_phase == 0 || m_phase == 3) && m_dwell < MIN_GREEN) lo = 4;
         end
         m_phase = p; m_dwell = 1;
      end
      m_evt = (lo != 0);
      if (lo != 0 && (!m_fault || clr)) begin
         m_fault = 1; m_code = lo;
      end else if (clr) begin
         m_fault = 0; m_code = 0;
      end
   endtask

   task automatic step(logic [5:0] l, bit clr);
      {tl_if.r1, tl_if.y1, tl_if.g1, tl_if.r2, tl_if.y2, tl_if.g2} = l;
      tl_if.fault_clr = clr;
      @(posedge clk);
      model_sample(l, clr);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      {tl_if.r1, tl_if.y1, tl_if.g1, tl_if.r2, tl_if.y2, tl_if.g2} = 6'b0;
      tl_if.fault_clr = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      n_cmp++;
      if (obs_vec() !== {3'd7, 1'b0, 7'd0, 1'b0, 3'd0, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_state: got %h expected %h", obs_vec(), {3'd7, 1'b0, 7'd0, 1'b0, 3'd0, 1'b0});
      end
   endtask

   task automatic test_legal_cycle();
      logic [5:0] seq [5] = '{L_G1R2, L_Y1R2, L_R1G2, L_R1Y2, L_G1R2};
      int         len [5] = '{5, 2, 5, 2, 5};
      int         ph  [5] = '{0, 1, 3, 4, 0};
      for (int s = 0; s < 5; s++) begin
         for (int k = 1; k <= len[s]; k++) begin
            step(seq[s], 1'b0);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
               n_bad++;
               $display("FAIL legal_cycle_model seg %0d cyc %0d: got %h expected %h", s, k, obs_vec(), exp_vec());
            end
         end
         n_cmp++;
         if ({tl_if.phase, tl_if.dwell, tl_if.fault, tl_if.fault_evt} !== {3'(ph[s]), 7'(len[s]), 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL legal_cycle_peak seg %0d: got phase %0d dwell %0d fault %b evt %b expected phase %0d dwell %0d no fault",
                     s, tl_if.phase, tl_if.dwell, tl_if.fault, tl_if.fault_evt, ph[s], len[s]);
         end
      end
   endtask

   task automatic test_illegal_pattern();
      step(L_G1G2, 1'b0);
      n_cmp++;
      if ({tl_if.phase, tl_if.phase_valid, tl_if.fault, tl_if.fault_code} !== {3'd7, 1'b0, 1'b1, 3'd1}) begin
         n_bad++;
         $display("FAIL illegal_pattern: got phase %0d valid %b fault %b code %0d expected 7 0 1 1",
                  tl_if.phase, tl_if.phase_valid, tl_if.fault, tl_if.fault_code);
      end
      step(L_G1R2, 1'b0);
      n_cmp++;
      if ({tl_if.phase, tl_if.dwell, tl_if.fault_code, tl_if.fault_evt} !== {3'd0, 7'd1, 3'd1, 1'b0}) begin
         n_bad++;
         $display("FAIL illegal_recover: got phase %0d dwell %0d code %0d evt %b expected 0 1 1 0",
                  tl_if.phase, tl_if.dwell, tl_if.fault_code, tl_if.fault_evt);
      end
   endtask

   task automatic test_short_yellow_latch();
      apply_reset();
      repeat (4) step(L_G1R2, 1'b0);
      step(L_Y1R2, 1'b0);
      step(L_R1G2, 1'b0);
      n_cmp++;
      if ({tl_if.fault, tl_if.fault_code, tl_if.fault_evt} !== {1'b1, 3'd3, 1'b1}) begin
         n_bad++;
         $display("FAIL short_yellow: got fault %b code %0d evt %b expected 1 3 1", tl_if.fault, tl_if.fault_code, tl_if.fault_evt);
      end
      step(L_R1G2, 1'b1);
      n_cmp++;
      if ({tl_if.fault, tl_if.fault_code, tl_if.dwell} !== {1'b0, 3'd0, 7'd2}) begin
         n_bad++;
         $display("FAIL fault_clr: got fault %b code %0d dwell %0d expected 0 0 2", tl_if.fault, tl_if.fault_code, tl_if.dwell);
      end
      step(L_G1R2, 1'b0);
      n_cmp++;
      if ({tl_if.fault, tl_if.fault_code} !== {1'b1, 3'd2}) begin
         n_bad++;
         $display("FAIL edge_over_green: got fault %b code %0d expected 1 2", tl_if.fault, tl_if.fault_code);
      end
   endtask

   task automatic test_stuck();
      apply_reset();
      for (int i = 1; i <= 70; i++) begin
         step(L_R1R2, 1'b0);
         n_cmp++;
         if (obs_vec() !== exp_vec() || tl_if.dwell !== 7'((i < MAX_DWELL) ? i : MAX_DWELL) ||
             tl_if.fault_evt !== (i >= 65)) begin
            n_bad++;
            $display("FAIL stuck cyc %0d: got %h (dwell %0d evt %b) expected %h", i, obs_vec(), tl_if.dwell, tl_if.fault_evt, exp_vec());
         end
      end
      n_cmp++;
      if ({tl_if.fault, tl_if.fault_code} !== {1'b1, 3'd5}) begin
         n_bad++;
         $display("FAIL stuck_code: got fault %b code %0d expected 1 5", tl_if.fault, tl_if.fault_code);
      end
   endtask

   task automatic test_clr_collision();
      step(L_R1R2, 1'b1);
      n_cmp++;
      if ({tl_if.fault, tl_if.fault_code, tl_if.fault_evt} !== {1'b1, 3'd5, 1'b1}) begin
         n_bad++;
         $display("FAIL clr_collision: got fault %b code %0d evt %b expected 1 5 1", tl_if.fault, tl_if.fault_code, tl_if.fault_evt);
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      step(L_G1G2, 1'b0);
      repeat (3) step(L_R1G2, 1'b0);
      n_cmp++;
      if ({tl_if.phase, tl_if.dwell, tl_if.fault} !== {3'd3, 7'd3, 1'b1}) begin
         n_bad++;
         $display("FAIL async_setup: got phase %0d dwell %0d fault %b expected 3 3 1", tl_if.phase, tl_if.dwell, tl_if.fault);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (obs_vec() !== {3'd7, 1'b0, 7'd0, 1'b0, 3'd0, 1'b0}) begin
         n_bad++;
         $display("FAIL async_reset: got %h expected %h", obs_vec(), {3'd7, 1'b0, 7'd0, 1'b0, 3'd0, 1'b0});
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(L_R1Y2, 1'b0);
      n_cmp++;
      if ({tl_if.phase, tl_if.dwell, tl_if.fault, tl_if.fault_evt} !== {3'd4, 7'd1, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL async_release: got phase %0d dwell %0d fault %b evt %b expected 4 1 0 0",
                  tl_if.phase, tl_if.dwell, tl_if.fault, tl_if.fault_evt);
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int seg = 0; seg < 80; seg++) begin
         logic [5:0] l;
         int         r;
         int         len;
         int         succ[$];
         r = $urandom_range(0, 9);
         if (r == 0) begin
            l = 6'($urandom());
         end else if (r <= 6) begin
            succ.delete();
            foreach (edges[i]) if (edges[i][0] == m_phase) succ.push_back(edges[i][1]);
            if (succ.size() == 0) l = lamp_of[$urandom_range(0, 4)];
            else l = lamp_of[succ[$urandom_range(0, succ.size() - 1)]];
         end else begin
            l = lamp_of[$urandom_range(0, 4)];
         end
         len = ($urandom_range(0, 19) == 0) ? 67 : $urandom_range(1, 7);
         for (int k = 0; k < len; k++) begin
            step(l, ($urandom_range(0, 9) == 0));
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
               n_bad++;
               $display("FAIL random seg %0d cyc %0d lamps %b: got %h expected %h", seg, k, l, obs_vec(), exp_vec());
            end
         end
      end
   endtask

   initial begin
      lamp_of = '{L_G1R2, L_Y1R2, L_R1R2, L_R1G2, L_R1Y2};
      test_reset();
      test_legal_cycle();
      test_illegal_pattern();
      test_short_yellow_latch();
      test_stuck();
      test_clr_collision();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not complete, compared %0d mismatched %0d", n_cmp, n_bad);
      $fatal(1);
   end
endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
Lamp-side observer for the two-road traffic light controller. It samples the six lamp drives (r1/y1/g1, r2/y2/g2) every clock and decodes them into a phase. It checks that each pattern and each phase transition is legal and that minimum and maximum dwell times are respected. The first fault is latched for the supervisor; it never drives the lamps.

Parameters:
MIN_GREEN, 4, minimum consecutive cycles a G1R2 or R1G2 phase must hold.
MIN_YELLOW, 2, minimum consecutive cycles a Y1R2 or R1Y2 phase must hold.
MAX_DWELL, 64, number of cycles of any single phase that raises the stuck fault.
CNT_W, 7, dwell counter width; must satisfy 2^CNT_W > MAX_DWELL.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
r1, y1, g1  in  1 each  road-1 lamp drives, same clock domain.
r2, y2, g2  in  1 each  road-2 lamp drives, same clock domain.
fault_clr  in  1  synchronous clear of the latched fault.
phase  out  3  decoded phase: 0 G1R2, 1 Y1R2, 2 R1R2, 3 R1G2, 4 R1Y2, 7 UNKNOWN.
phase_valid  out  1  high when phase != 7.
dwell  out  CNT_W  consecutive samples in the current phase; saturates at MAX_DWELL.
fault  out  1  sticky fault flag.
fault_code  out  3  first fault cause: 0 none, 1 illegal pattern, 2 illegal transition, 3 short yellow, 4 short green, 5 stuck.
fault_evt  out  1  one-cycle pulse on every detection, whether or not fault is already set.

Behaviour:
- Reset (rst_n low, asynchronous): phase=7, phase_valid=0, dwell=0, fault=0, fault_code=0, fault_evt=0. Release on a clk edge; monitoring starts at the first edge with rst_n high.
- All outputs are registered. The lamp pattern present before edge n is reflected in phase, dwell and fault after edge n, so latency is 1 cycle.
- Decode: a road is legal only when exactly one of its lamps is lit. The legal pairs are G1R2, Y1R2, R1R2, R1G2 and R1Y2. Every other combination is illegal, including G1G2, Y1Y2, G1Y2, Y1G2, any road with zero lamps lit, and any road with two or more lamps lit.
- Illegal pattern: phase<=7, dwell<=0, detect code 1.
- Same legal phase as the current phase: dwell<=dwell+1, saturating at MAX_DWELL. When dwell reaches MAX_DWELL and the same phase is sampled again, detect code 5. Code 5 re-detects on every such cycle, and fault_evt pulses each cycle.
- Change to a legal phase from UNKNOWN (after reset or after an illegal pattern): no transition or dwell check; phase<=new, dwell<=1.
- Change between legal phases: phase<=new, dwell<=1. Legal edges are:
  - G1R2->Y1R2
  - Y1R2->R1R2
  - Y1R2->R1G2
  - R1R2->R1G2
  - R1R2->G1R2
  - R1G2->R1Y2
  - R1Y2->R1R2
  - R1Y2->G1R2
  Any other change detects code 2.
- Dwell checks on a change (independent of code 2):
  - Leaving a yellow phase with dwell < MIN_YELLOW detects code 3.
  - Leaving a green phase with dwell < MIN_GREEN detects code 4.
  - R1R2 has no minimum.
- Simultaneous detections in one cycle: the lowest code number wins for latching. fault_evt is a single pulse.
- Latch: if fault=0 and a detection occurs, then fault<=1 and fault_code<=detected code. If fault=1, fault_code holds its value; later detections only pulse fault_evt.
- fault_clr: sets fault and fault_code to 0 at the edge. If a detection occurs in the same cycle, the detection wins: fault=1 with the new code. fault_clr does not affect phase or dwell.
- Monitoring continues normally after a fault.
- Reset asserted mid-phase returns all outputs to reset values immediately. The first sample after release is treated as "from UNKNOWN", so no transition or dwell check applies.

Test Plan:
- Legal cycle: after reset drive G1R2 x5, Y1R2 x2, R1G2 x5, R1Y2 x2, G1R2 x5 -> phase sequence 0,1,3,4,0 (each 1 cycle late); dwell peaks 5,2,5,2; fault=0 and fault_evt never high.
- Illegal pattern: in G1R2 drive g1=g2=1 (r1=r2=0) for 1 cycle -> next cycle phase=7, phase_valid=0, fault=1, fault_code=1; returning to G1R2 gives phase=0, dwell=1 with no code-2 fault.
- Short yellow plus latch: after G1R2 x4, drive Y1R2 x1 then R1G2 -> fault_code=3. Then fault_clr=1 for one cycle -> fault=0. Then R1G2 x2 followed by G1R2 -> fault_code=2 (R1G2->G1R2 is an illegal edge) and 4 is not latched. Check the latched code is 2, which has priority over 4 when both occur in the same cycle.
- Stuck: hold R1R2 for 70 cycles -> dwell saturates at 64; fault_code=5 asserted after the 65th sample; fault_evt pulses on cycles 65-70.
- fault_clr collision: with fault=1 (code 5, R1R2 held), assert fault_clr on a cycle that also detects stuck -> fault stays 1 and fault_code=5.
- Async reset: assert rst_n low mid-cycle during R1G2 with dwell=3 and fault=1 -> all outputs zero or phase=7 before the next clk edge. After release, drive R1Y2 x1 -> phase=4, dwell=1, no fault.
